// File: rtl/heavy_hash_result_collector.sv
// Collects four 64-bit heavy-hash words, compares the 256-bit hash against a target, and reports winning nonces.
// Optional found_hash output enabled by defining HH_COLLECT_FOUND_HASH_EN.
module heavy_hash_result_collector #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      hh_data,
   input  logic             hh_we,
   output logic             hh_stall,
   input  logic [31:0]      nonce,
   output logic             nonce_re,
   input  logic             target_we,
   input  logic [1:0]       target_idx,
   input  logic [63:0]      target_din,
   output logic             found_valid,
   input  logic             found_ack,
   output logic [31:0]      found_nonce,
   output logic [CNT_W-1:0] hash_count,
   output logic             drop_err
`ifdef HH_COLLECT_FOUND_HASH_EN
   ,
   output logic [255:0]     found_hash
`endif
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      POP     = 2'd1,
      LATCH   = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [1:0]        word_cnt;
   logic [255:0]      hash_buf;
   logic [3:0][63:0]  target_words;
   logic              match_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= COLLECT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      hh_stall    = 1'b1;
      nonce_re    = 1'b0;
      found_valid = 1'b0;
      case (state)
         COLLECT: begin
            hh_stall = 1'b0;
            if (hh_we && (word_cnt == 2'd3)) begin
               next_state = POP;
            end
         end
         POP: begin
            nonce_re   = 1'b1;
            next_state = LATCH;
         end
         LATCH: begin
            next_state = match_q ? REPORT : COLLECT;
         end
         REPORT: begin
            found_valid = 1'b1;
            if (found_ack) begin
               next_state = COLLECT;
            end
         end
         default: begin
            next_state = COLLECT;
         end
      endcase
   end

   // Word counter wraps 3 -> 0 on its own, so it is already clear when COLLECT resumes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
         hash_buf <= '0;
      end else if ((state == COLLECT) && hh_we) begin
         hash_buf[{word_cnt, 6'd0} +: 64] <= hh_data;
         word_cnt                         <= word_cnt + 2'd1;
      end
   end

   // Compare uses the target as it stood before any write landing on the POP edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target_words <= '1;
         match_q      <= 1'b0;
      end else begin
         if (target_we) begin
            target_words[target_idx] <= target_din;
         end
         if (state == POP) begin
            match_q <= (hash_buf <= target_words);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hash_count  <= '0;
         found_nonce <= '0;
         drop_err    <= 1'b0;
`ifdef HH_COLLECT_FOUND_HASH_EN
         found_hash  <= '0;
`endif
      end else begin
         if (hh_we && hh_stall) begin
            drop_err <= 1'b1;
         end
         if (state == LATCH) begin
            hash_count <= hash_count + CNT_W'(1);
            if (match_q) begin
               found_nonce <= nonce;
`ifdef HH_COLLECT_FOUND_HASH_EN
               found_hash  <= hash_buf;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_heavy_hash_result_collector.sv
// Scoreboard bench for heavy_hash_result_collector: directed hashes, expected finds queued, monitor compares.
module tb_heavy_hash_result_collector;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   hh_data;
   logic          hh_we;
   logic          hh_stall;
   logic [31:0]   nonce;
   logic          nonce_re;
   logic          target_we;
   logic [1:0]    target_idx;
   logic [63:0]   target_din;
   logic          found_valid;
   logic          found_ack;
   logic [31:0]   found_nonce;
   logic [31:0]   hash_count;
   logic          drop_err;
`ifdef HH_COLLECT_FOUND_HASH_EN
   logic [255:0]  found_hash;
`endif

   heavy_hash_result_collector #(.CNT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .hh_data     (hh_data),
      .hh_we       (hh_we),
      .hh_stall    (hh_stall),
      .nonce       (nonce),
      .nonce_re    (nonce_re),
      .target_we   (target_we),
      .target_idx  (target_idx),
      .target_din  (target_din),
      .found_valid (found_valid),
      .found_ack   (found_ack),
      .found_nonce (found_nonce),
      .hash_count  (hash_count),
      .drop_err    (drop_err)
`ifdef HH_COLLECT_FOUND_HASH_EN
      ,
      .found_hash  (found_hash)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  n;
      logic [255:0] h;
   } exp_t;

   exp_t          exp_q[$];
   logic [31:0]   nonce_q[$];
   int            vectors    = 0;
   int            miscompares = 0;
   int            pops       = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: models the nonce FIFO and scores every reported find.
   initial begin
      bit          seen = 1'b0;
      logic [31:0] held = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (nonce_re) begin
            pops++;
            if (nonce_q.size() > 0) nonce = nonce_q.pop_front();
         end
         if (found_valid) begin
            if (!seen) begin
               seen = 1'b1;
               held = found_nonce;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_found: got nonce %0h expected no report", found_nonce);
               end else begin
                  e = exp_q.pop_front();
                  check("found_nonce", found_nonce, e.n);
`ifdef HH_COLLECT_FOUND_HASH_EN
                  check("found_hash", found_hash, e.h);
`endif
               end
            end else begin
               check("found_nonce_stable", found_nonce, held);
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   task automatic send_hash(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                            input logic [63:0] w3, input logic [31:0] n, input bit match,
                            input bit tw, input logic [1:0] ti, input logic [63:0] td);
      logic [63:0] w[4];
      exp_t        e;
      w = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_collect", hh_stall, 1'b0);
         hh_we   = 1'b1;
         hh_data = w[i];
      end
      nonce_q.push_back(n);
      if (match) begin
         e.n = n;
         e.h = {w3, w2, w1, w0};
         exp_q.push_back(e);
      end
      @(negedge clk);
      hh_we   = 1'b0;
      hh_data = '0;
      check("nonce_re_pop", nonce_re, 1'b1);
      check("stall_pop", hh_stall, 1'b1);
      if (tw) begin
         target_we  = 1'b1;
         target_idx = ti;
         target_din = td;
      end
      @(negedge clk);
      target_we = 1'b0;
      check("nonce_re_latch", nonce_re, 1'b0);
      check("found_valid_latch", found_valid, 1'b0);
      @(negedge clk);
      check("found_valid_n3", found_valid, match);
      check("stall_n3", hh_stall, match);
   endtask

   task automatic ack_found();
      found_ack = 1'b1;
      @(negedge clk);
      found_ack = 1'b0;
      check("found_valid_after_ack", found_valid, 1'b0);
      check("stall_after_ack", hh_stall, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      hh_data    = '0;
      hh_we      = 1'b0;
      nonce      = '0;
      target_we  = 1'b0;
      target_idx = '0;
      target_din = '0;
      found_ack  = 1'b0;

      @(negedge clk);
      check("rst_stall", hh_stall, 1'b0);
      check("rst_nonce_re", nonce_re, 1'b0);
      check("rst_found_valid", found_valid, 1'b0);
      check("rst_found_nonce", found_nonce, 32'h0);
      check("rst_hash_count", hash_count, 32'h0);
      check("rst_drop_err", drop_err, 1'b0);
      rst = 1'b1;

      // All-ones reset target: anything matches.
      send_hash(64'h1, 64'h2, 64'h3, 64'h4, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 64'h0);
      check("count_t1", hash_count, 32'd1);
      check("drop_t1", drop_err, 1'b0);
      ack_found();

      // Hash just above target: no report.
      @(negedge clk);
      target_we  = 1'b1;
      target_idx = 2'd3;
      target_din = 64'h0000_FFFF_FFFF_FFFF;
      @(negedge clk);
      target_we = 1'b0;
      send_hash(64'h0, 64'h0, 64'h0, 64'h0001_0000_0000_0000, 32'h11111111, 1'b0, 1'b0, 2'd0, 64'h0);
      check("count_t2", hash_count, 32'd2);

      // Hash equal to target, then hold off ack while words keep arriving.
      send_hash('1, '1, '1, 64'h0000_FFFF_FFFF_FFFF, 32'h22222222, 1'b1, 1'b0, 2'd0, 64'h0);
      check("count_t3", hash_count, 32'd3);
      for (int i = 0; i < 10; i++) begin
         hh_we   = 1'b1;
         hh_data = 64'hBAD0_0000_0000_0000 | 64'(i);
         @(negedge clk);
         check("stall_report", hh_stall, 1'b1);
         check("valid_report", found_valid, 1'b1);
      end
      hh_we   = 1'b0;
      hh_data = '0;
      check("drop_err_set", drop_err, 1'b1);
      ack_found();

      // Ack outside REPORT is ignored; target write during POP does not affect that compare.
      found_ack = 1'b1;
      @(negedge clk);
      found_ack = 1'b0;
      check("stray_ack", found_valid, 1'b0);
      send_hash(64'h0, 64'h0, 64'h0, 64'h1, 32'h33333333, 1'b1, 1'b1, 2'd3, 64'h0);
      ack_found();
      send_hash(64'h0, 64'h0, 64'h0, 64'h1, 32'h55555555, 1'b0, 1'b0, 2'd0, 64'h0);
      check("count_t4", hash_count, 32'd5);
      check("drop_sticky", drop_err, 1'b1);

      // Reset mid-hash.
      @(negedge clk);
      hh_we   = 1'b1;
      hh_data = 64'h99;
      @(negedge clk);
      hh_data = 64'h98;
      @(negedge clk);
      hh_we   = 1'b0;
      rst     = 1'b0;
      #1;
      check("midrst_count", hash_count, 32'h0);
      check("midrst_drop", drop_err, 1'b0);
      check("midrst_stall", hh_stall, 1'b0);
      check("midrst_found_nonce", found_nonce, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      send_hash(64'h5, 64'h6, 64'h7, 64'h8, 32'h44444444, 1'b1, 1'b0, 2'd0, 64'h0);
      check("count_t5", hash_count, 32'd1);
      ack_found();

      send_hash(64'hA, 64'hB, 64'hC, 64'hD, 32'h66666666, 1'b1, 1'b0, 2'd0, 64'h0);
      check("count_t6", hash_count, 32'd2);
      ack_found();

      repeat (3) @(negedge clk);
      check("pops_total", 32'(pops), 32'd7);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("nonce_q_drained", 32'(nonce_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
